// File: rtl/fp_pkg.sv
// ---------------------------------------------------------------------------
// fp_pkg
// Shared floating-point helpers for the FPU datapath blocks.
//   fp_class_t   : operand / result classification
//   fpClassify   : decode a class from exponent/fraction summary bits
//   fpCanonNan   : canonical quiet NaN {0, all-ones exp, 1, zeros}
//   fpInf        : +/- infinity for a given sign
//   fpLzc        : leading-zero count over the low 'width' bits of a vector
// The constant builders return a FP_MAXW-wide vector; callers take the low
// 1+expWidth+mantWidth bits with a size cast.
// ---------------------------------------------------------------------------
package fp_pkg;

  typedef enum logic [1:0] {
    FP_NORM,
    FP_ZERO,
    FP_INF,
    FP_NAN
  } fp_class_t;

  localparam int FP_MAXW = 128;

  // Subnormals (exp == 0) are treated as zero by this FPU.
  function automatic fp_class_t fpClassify(input logic expZero,
                                           input logic expOnes,
                                           input logic fracNonZero);
    fp_class_t cls;
    if (expZero)       cls = FP_ZERO;
    else if (!expOnes) cls = FP_NORM;
    else if (fracNonZero) cls = FP_NAN;
    else               cls = FP_INF;
    return cls;
  endfunction

  function automatic logic [FP_MAXW-1:0] fpCanonNan(input int expWidth,
                                                    input int mantWidth);
    logic [FP_MAXW-1:0] v;
    v = '0;
    for (int i = 0; i < FP_MAXW; i++) begin
      if (i >= mantWidth && i < mantWidth + expWidth) v[i] = 1'b1;
      if (i == mantWidth - 1) v[i] = 1'b1;
    end
    return v;
  endfunction

  function automatic logic [FP_MAXW-1:0] fpInf(input int expWidth,
                                               input int mantWidth,
                                               input logic sign);
    logic [FP_MAXW-1:0] v;
    v = '0;
    for (int i = 0; i < FP_MAXW; i++) begin
      if (i >= mantWidth && i < mantWidth + expWidth) v[i] = 1'b1;
      if (i == mantWidth + expWidth) v[i] = sign;
    end
    return v;
  endfunction

  // Ascending scan: the highest set bit is the last one to overwrite count.
  function automatic int fpLzc(input logic [FP_MAXW-1:0] v, input int width);
    int count;
    count = width;
    for (int i = 0; i < FP_MAXW; i++) begin
      if (i < width && v[i]) count = width - 1 - i;
    end
    return count;
  endfunction

endpackage

// File: rtl/fp_norm_round.sv
// ---------------------------------------------------------------------------
// fp_norm_round
// Combinational normalise / round-to-nearest-even / pack with flag
// generation. Shared between the adder and the planned multiplier.
// Ports:
//   resCls    in   class of the result (FP_NAN / FP_INF override arithmetic)
//   sign      in   result sign (also the sign of an FP_INF result)
//   zeroSign  in   sign to use if the raw sum is exactly zero
//   exp       in   exponent of the larger operand
//   sum       in   {carry, hidden, fraction, guard, round, sticky}
//   y         out  packed IEEE result
//   nan, zero, overflow, inexact  out  result flags
// ---------------------------------------------------------------------------
module fp_norm_round
  import fp_pkg::*;
#(
  parameter int EXPWIDTH  = 8,
  parameter int MANTWIDTH = 23,
  localparam int W = 1 + EXPWIDTH + MANTWIDTH
) (
  input  fp_class_t              resCls,
  input  logic                   sign,
  input  logic                   zeroSign,
  input  logic [EXPWIDTH-1:0]    exp,
  input  logic [MANTWIDTH+4:0]   sum,
  output logic [W-1:0]           y,
  output logic                   nan,
  output logic                   zero,
  output logic                   overflow,
  output logic                   inexact
);

  localparam int M      = MANTWIDTH;
  localparam int MAXEXP = (1 << EXPWIDTH) - 1;
  localparam logic [W-1:0] NAN_Y   = W'(fpCanonNan(EXPWIDTH, MANTWIDTH));
  localparam logic [W-1:0] INF_Y   = W'(fpInf(EXPWIDTH, MANTWIDTH, 1'b0));
  localparam logic [W-1:0] SIGN_Y  = {1'b1, {(W-1){1'b0}}};

  logic [M+3:0] norm;      // {hidden, fraction, guard, round, sticky}
  logic [M+1:0] mantR;     // {carry, hidden, fraction} after rounding
  logic [M-1:0] fracR;
  logic         roundUp;
  logic         signBit;
  int           lz;
  int           expN;
  int           expR;

  always_comb begin
    norm     = '0;
    lz       = 0;
    expN     = 0;
    expR     = 0;
    roundUp  = 1'b0;
    mantR    = '0;
    fracR    = '0;
    signBit  = sign;
    y        = '0;
    nan      = 1'b0;
    overflow = 1'b0;
    inexact  = 1'b0;

    if (sum[M+4]) begin
      // Carry out: shift right one, folding the dropped bit into sticky.
      norm = {sum[M+4:2], sum[1] | sum[0]};
      expN = int'(exp) + 1;
    end else begin
      lz   = fpLzc(FP_MAXW'(sum[M+3:0]), M + 4);
      norm = sum[M+3:0] << lz;
      expN = int'(exp) - lz;
    end

    roundUp = norm[2] & (norm[1] | norm[0] | norm[3]);
    mantR   = {1'b0, norm[M+3:3]} + (M+2)'(roundUp);
    // A rounding carry means the mantissa became 10.000..., fraction all zero.
    expR    = expN + (mantR[M+1] ? 1 : 0);
    fracR   = mantR[M+1] ? mantR[M:1] : mantR[M-1:0];

    case (resCls)
      FP_NAN: begin
        y   = NAN_Y;
        nan = 1'b1;
      end
      FP_INF: begin
        y = INF_Y | (sign ? SIGN_Y : '0);
      end
      default: begin
        if (sum == '0) begin
          y = zeroSign ? SIGN_Y : '0;
        end else if (expN <= 0) begin
          // Below the minimum normal: flush to signed zero.
          y       = signBit ? SIGN_Y : '0;
          inexact = 1'b1;
        end else if (expR >= MAXEXP) begin
          y        = INF_Y | (signBit ? SIGN_Y : '0);
          overflow = 1'b1;
          inexact  = 1'b1;
        end else begin
          y       = {signBit, expR[EXPWIDTH-1:0], fracR};
          inexact = |norm[2:0];
        end
      end
    endcase
  end

  assign zero = ~|y[W-2:0];

endmodule

// File: rtl/fp_addsub_stream.sv
// ---------------------------------------------------------------------------
// fp_addsub_stream
// Streaming IEEE-754 adder/subtractor, 3 pipeline stages (align, add,
// normalise/round) under valid/ready flow control, RNE rounding, subnormal
// flush-to-zero, full special-value handling and per-result flags.
// Ports:
//   clk, ci_rst           clock, asynchronous active-high reset
//   diA, diB              operands
//   ciADD_n               0 = A+B, 1 = A-B
//   diTag                 opaque tag returned with the result
//   ciValid / coReady     input handshake
//   doY, doTag            result and its tag
//   coValid / ciReady     output handshake
//   coNAN, coZero, coOverflow, coInexact   result flags (qualified by coValid)
// ---------------------------------------------------------------------------
module fp_addsub_stream
  import fp_pkg::*;
#(
  parameter int EXPWIDTH  = 8,
  parameter int MANTWIDTH = 23,
  parameter int TAGWIDTH  = 4,
  localparam int W = 1 + EXPWIDTH + MANTWIDTH
) (
  input  logic                clk,
  input  logic                ci_rst,
  input  logic [W-1:0]        diA,
  input  logic [W-1:0]        diB,
  input  logic                ciADD_n,
  input  logic [TAGWIDTH-1:0] diTag,
  input  logic                ciValid,
  output logic                coReady,
  output logic [W-1:0]        doY,
  output logic [TAGWIDTH-1:0] doTag,
  output logic                coValid,
  input  logic                ciReady,
  output logic                coNAN,
  output logic                coZero,
  output logic                coOverflow,
  output logic                coInexact
);

  localparam int E = EXPWIDTH;
  localparam int M = MANTWIDTH;

  // ---------------- flow control ----------------
  logic vA, vB, vC;
  logic enA, enB, enC;

  // A stage loads when it is empty or its successor moves on.
  assign enC     = !vC || ciReady;
  assign enB     = !vB || enC;
  assign enA     = !vA || enB;
  assign coReady = enA;
  assign coValid = vC;

  // ---------------- stage A: decode, swap, align ----------------
  logic [E-1:0]   expA, expB;
  logic [M-1:0]   fracA, fracB;
  logic           signA, signB;
  fp_class_t      clsA, clsB;
  logic [W-2:0]   magA, magB;
  logic           swap;

  assign expA  = diA[W-2:M];
  assign expB  = diB[W-2:M];
  assign fracA = diA[M-1:0];
  assign fracB = diB[M-1:0];
  assign signA = diA[W-1];
  assign signB = diB[W-1] ^ ciADD_n;   // subtraction is addition of -B
  assign clsA  = fpClassify(expA == '0, &expA, |fracA);
  assign clsB  = fpClassify(expB == '0, &expB, |fracB);
  // Flushed subnormals compare as zero magnitude.
  assign magA  = (clsA == FP_ZERO) ? '0 : diA[W-2:0];
  assign magB  = (clsB == FP_ZERO) ? '0 : diB[W-2:0];
  assign swap  = magB > magA;

  logic [E-1:0]     bigExp, smallExp, expDiff;
  logic [M-1:0]     bigFrac, smallFrac;
  logic             bigNorm, smallNorm, bigSign, smallSign;
  logic [M+3:0]     bigSig, smallSig;
  logic [M+2:0]     smallVal;
  logic [2*M+5:0]   wideSmall;
  int               shiftAmt;
  fp_class_t        clsNext;
  logic             signNext;

  always_comb begin
    bigExp    = swap ? expB : expA;
    smallExp  = swap ? expA : expB;
    bigNorm   = swap ? (clsB == FP_NORM) : (clsA == FP_NORM);
    smallNorm = swap ? (clsA == FP_NORM) : (clsB == FP_NORM);
    bigSign   = swap ? signB : signA;
    smallSign = swap ? signA : signB;
    bigFrac   = bigNorm ? (swap ? fracB : fracA) : '0;
    smallFrac = smallNorm ? (swap ? fracA : fracB) : '0;
    expDiff   = bigExp - smallExp;

    // Distances of M+3 or more leave nothing but sticky; clamping there
    // keeps the shifter bounded without changing the result.
    shiftAmt  = (int'(expDiff) >= M + 3) ? M + 3 : int'(expDiff);

    bigSig    = {bigNorm, bigFrac, 3'b000};
    smallVal  = {smallNorm, smallFrac, 2'b00};
    wideSmall = {smallVal, {(M+3){1'b0}}} >> shiftAmt;
    smallSig  = {wideSmall[2*M+5:M+3], |wideSmall[M+2:0]};

    // Special-value priority: NaN, then infinity, then arithmetic.
    clsNext  = FP_NORM;
    signNext = bigSign;
    if (clsA == FP_NAN || clsB == FP_NAN ||
        (clsA == FP_INF && clsB == FP_INF && signA != signB)) begin
      clsNext  = FP_NAN;
      signNext = 1'b0;
    end else if (clsA == FP_INF) begin
      clsNext  = FP_INF;
      signNext = signA;
    end else if (clsB == FP_INF) begin
      clsNext  = FP_INF;
      signNext = signB;
    end
  end

  logic [TAGWIDTH-1:0] aTag;
  fp_class_t           aCls;
  logic                aSign, aZeroSign, aSub;
  logic [E-1:0]        aExp;
  logic [M+3:0]        aBig, aSmall;

  always_ff @(posedge clk or posedge ci_rst) begin
    if (ci_rst) begin
      vA        <= 1'b0;
      aTag      <= '0;
      aCls      <= FP_NORM;
      aSign     <= 1'b0;
      aZeroSign <= 1'b0;
      aSub      <= 1'b0;
      aExp      <= '0;
      aBig      <= '0;
      aSmall    <= '0;
    end else if (enA) begin
      vA        <= ciValid;
      aTag      <= diTag;
      aCls      <= clsNext;
      aSign     <= signNext;
      // An exact-zero sum is -0 only when both addends are negative.
      aZeroSign <= signA & signB;
      aSub      <= bigSign ^ smallSign;
      aExp      <= bigExp;
      aBig      <= bigSig;
      aSmall    <= smallSig;
    end
  end

  // ---------------- stage B: magnitude add/subtract ----------------
  logic [M+4:0] sumNext;

  // The swap guarantees aBig >= aSmall, so subtraction never wraps.
  assign sumNext = aSub ? ({1'b0, aBig} - {1'b0, aSmall})
                        : ({1'b0, aBig} + {1'b0, aSmall});

  logic [TAGWIDTH-1:0] bTag;
  fp_class_t           bCls;
  logic                bSign, bZeroSign;
  logic [E-1:0]        bExp;
  logic [M+4:0]        bSum;

  always_ff @(posedge clk or posedge ci_rst) begin
    if (ci_rst) begin
      vB        <= 1'b0;
      bTag      <= '0;
      bCls      <= FP_NORM;
      bSign     <= 1'b0;
      bZeroSign <= 1'b0;
      bExp      <= '0;
      bSum      <= '0;
    end else if (enB) begin
      vB        <= vA;
      bTag      <= aTag;
      bCls      <= aCls;
      bSign     <= aSign;
      bZeroSign <= aZeroSign;
      bExp      <= aExp;
      bSum      <= sumNext;
    end
  end

  // ---------------- stage C: normalise, round, pack ----------------
  logic [W-1:0] yNext;
  logic         nanNext, zeroNext, ovfNext, inexNext;

  fp_norm_round #(
    .EXPWIDTH (EXPWIDTH),
    .MANTWIDTH(MANTWIDTH)
  ) uNormRound (
    .resCls  (bCls),
    .sign    (bSign),
    .zeroSign(bZeroSign),
    .exp     (bExp),
    .sum     (bSum),
    .y       (yNext),
    .nan     (nanNext),
    .zero    (zeroNext),
    .overflow(ovfNext),
    .inexact (inexNext)
  );

  always_ff @(posedge clk or posedge ci_rst) begin
    if (ci_rst) begin
      vC         <= 1'b0;
      doTag      <= '0;
      doY        <= '0;
      coNAN      <= 1'b0;
      coZero     <= 1'b0;
      coOverflow <= 1'b0;
      coInexact  <= 1'b0;
    end else if (enC) begin
      vC         <= vB;
      doTag      <= bTag;
      doY        <= yNext;
      coNAN      <= nanNext;
      coZero     <= zeroNext;
      coOverflow <= ovfNext;
      coInexact  <= inexNext;
    end
  end

endmodule

// File: tb/tb_fp_addsub_stream.sv
// ---------------------------------------------------------------------------
// tb_fp_addsub_stream
// Directed bench for fp_addsub_stream (binary32). Expected results are
// pushed to a scoreboard queue when an operation is accepted and popped by
// the output monitor on each output transfer.
// ---------------------------------------------------------------------------
module tb_fp_addsub_stream;

  localparam int E = 8;
  localparam int M = 23;
  localparam int T = 4;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         ci_rst;
  logic [W-1:0] diA, diB;
  logic         ciADD_n;
  logic [T-1:0] diTag;
  logic         ciValid;
  logic         coReady;
  logic [W-1:0] doY;
  logic [T-1:0] doTag;
  logic         coValid;
  logic         ciReady;
  logic         coNAN, coZero, coOverflow, coInexact;

  always #5 clk = ~clk;

  fp_addsub_stream #(
    .EXPWIDTH (E),
    .MANTWIDTH(M),
    .TAGWIDTH (T)
  ) dut (
    .clk       (clk),
    .ci_rst    (ci_rst),
    .diA       (diA),
    .diB       (diB),
    .ciADD_n   (ciADD_n),
    .diTag     (diTag),
    .ciValid   (ciValid),
    .coReady   (coReady),
    .doY       (doY),
    .doTag     (doTag),
    .coValid   (coValid),
    .ciReady   (ciReady),
    .coNAN     (coNAN),
    .coZero    (coZero),
    .coOverflow(coOverflow),
    .coInexact (coInexact)
  );

  typedef struct packed {
    logic [W-1:0] y;
    logic [T-1:0] tag;
    logic         nan;
    logic         zero;
    logic         ovf;
    logic         inex;
  } exp_t;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         sub;
    exp_t         want;
  } vec_t;

  exp_t sbQ[$];
  int   nAssert  = 0;
  int   nFail    = 0;
  int   outCount = 0;

  function automatic exp_t mk(input logic [W-1:0] y, input logic [T-1:0] tag,
                              input logic n, input logic z, input logic o,
                              input logic i);
    return {y, tag, n, z, o, i};
  endfunction

  // Output monitor: sampled on the falling edge, between active edges.
  always @(negedge clk) begin : monitor
    exp_t got;
    exp_t want;
    if (!ci_rst && coValid && ciReady) begin
      got = {doY, doTag, coNAN, coZero, coOverflow, coInexact};
      outCount++;
      nAssert++;
      if (sbQ.size() == 0) begin
        nFail++;
        $display("FAIL unexpected_output: got y=%h tag=%0d, required no output", doY, doTag);
      end else begin
        want = sbQ.pop_front();
        if (got !== want) begin
          nFail++;
          $display("FAIL result: got y=%h tag=%0d nan=%b zero=%b ovf=%b inex=%b, required y=%h tag=%0d nan=%b zero=%b ovf=%b inex=%b",
                   got.y, got.tag, got.nan, got.zero, got.ovf, got.inex,
                   want.y, want.tag, want.nan, want.zero, want.ovf, want.inex);
        end else begin
          $display("result y=%h tag=%0d flags(n,z,o,i)=%b%b%b%b ok",
                   got.y, got.tag, got.nan, got.zero, got.ovf, got.inex);
        end
      end
    end
  end

  task automatic loadOp(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic sub, input logic [T-1:0] tag);
    diA     = a;
    diB     = b;
    ciADD_n = sub;
    diTag   = tag;
    ciValid = 1'b1;
  endtask

  // Presents one operation and holds it until accepted (bounded).
  task automatic sendOp(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic sub, input exp_t want);
    int guard;
    loadOp(a, b, sub, want.tag);
    guard = 0;
    @(negedge clk);
    while (!coReady && guard < 50) begin
      guard++;
      @(negedge clk);
    end
    if (!coReady) begin
      nAssert++;
      nFail++;
      $display("FAIL send_stall: got coReady=%b for 50 cycles, required 1", coReady);
    end else begin
      sbQ.push_back(want);
    end
    @(posedge clk);
    #1;
    ciValid = 1'b0;
  endtask

  task automatic waitDrain(input int limit);
    int g;
    g = 0;
    while (sbQ.size() != 0 && g < limit) begin
      @(negedge clk);
      g++;
    end
    nAssert++;
    if (sbQ.size() != 0) begin
      nFail++;
      $display("FAIL drain_timeout: got %0d results pending, required 0", sbQ.size());
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    ci_rst  = 1'b1;
    ciValid = 1'b0;
    ciReady = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    nAssert++;
    if ({coValid, doY, doTag, coNAN, coZero, coOverflow, coInexact} !== '0) begin
      nFail++;
      $display("FAIL reset_outputs: got valid=%b y=%h tag=%0d flags=%b%b%b%b, required all 0",
               coValid, doY, doTag, coNAN, coZero, coOverflow, coInexact);
    end
    ci_rst = 1'b0;
    @(posedge clk);
    #1;
    nAssert++;
    if (coReady !== 1'b1 || coValid !== 1'b0) begin
      nFail++;
      $display("FAIL reset_release: got ready=%b valid=%b, required ready=1 valid=0", coReady, coValid);
    end
    $display("reset check done");
  endtask

  // Operation presented after edge n, accepted at edge n+1; coValid must
  // rise only after edge n+3.
  task automatic test_basic();
    ciReady = 1'b1;
    loadOp(32'h3F800000, 32'h40000000, 1'b0, 4'd5);
    nAssert++;
    if (coReady !== 1'b1) begin
      nFail++;
      $display("FAIL ready_idle: got %b, required 1", coReady);
    end
    @(posedge clk);
    sbQ.push_back(mk(32'h40400000, 4'd5, 1'b0, 1'b0, 1'b0, 1'b0));
    #1;
    ciValid = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      nAssert++;
      if (coValid !== (k == 3)) begin
        nFail++;
        $display("FAIL latency: got coValid=%b after edge n+%0d, required %b", coValid, k + 1, (k == 3));
      end
    end
    waitDrain(10);
  endtask

  task automatic test_arith();
    vec_t v[14];
    v[0]  = '{32'h3F800000, 32'h3F800000, 1'b1, mk(32'h00000000, 4'd1,  1'b0, 1'b1, 1'b0, 1'b0)};
    v[1]  = '{32'h80000000, 32'h80000000, 1'b0, mk(32'h80000000, 4'd2,  1'b0, 1'b1, 1'b0, 1'b0)};
    v[2]  = '{32'h3F800000, 32'h33800000, 1'b0, mk(32'h3F800000, 4'd3,  1'b0, 1'b0, 1'b0, 1'b1)};
    v[3]  = '{32'h3F800001, 32'h33800000, 1'b0, mk(32'h3F800002, 4'd4,  1'b0, 1'b0, 1'b0, 1'b1)};
    v[4]  = '{32'h40400000, 32'h40000000, 1'b1, mk(32'h3F800000, 4'd6,  1'b0, 1'b0, 1'b0, 1'b0)};
    v[5]  = '{32'h00800000, 32'h00800001, 1'b1, mk(32'h80000000, 4'd7,  1'b0, 1'b1, 1'b0, 1'b1)};
    v[6]  = '{32'h7F800000, 32'h3F800000, 1'b0, mk(32'h7F800000, 4'd8,  1'b0, 1'b0, 1'b0, 1'b0)};
    v[7]  = '{32'h7FC00001, 32'h3F800000, 1'b0, mk(32'h7FC00000, 4'd9,  1'b1, 1'b0, 1'b0, 1'b0)};
    v[8]  = '{32'h7F800000, 32'hFF800000, 1'b0, mk(32'h7FC00000, 4'd10, 1'b1, 1'b0, 1'b0, 1'b0)};
    v[9]  = '{32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, mk(32'h7F800000, 4'd11, 1'b0, 1'b0, 1'b1, 1'b1)};
    v[10] = '{32'h7F800000, 32'h7F800000, 1'b1, mk(32'h7FC00000, 4'd12, 1'b1, 1'b0, 1'b0, 1'b0)};
    v[11] = '{32'h3F800000, 32'h00000001, 1'b0, mk(32'h3F800000, 4'd13, 1'b0, 1'b0, 1'b0, 1'b0)};
    v[12] = '{32'hBF800000, 32'h3F000000, 1'b0, mk(32'hBF000000, 4'd14, 1'b0, 1'b0, 1'b0, 1'b0)};
    v[13] = '{32'hFF800000, 32'h7F7FFFFF, 1'b0, mk(32'hFF800000, 4'd15, 1'b0, 1'b0, 1'b0, 1'b0)};
    ciReady = 1'b1;
    foreach (v[i]) sendOp(v[i].a, v[i].b, v[i].sub, v[i].want);
    waitDrain(20);
  endtask

  task automatic test_backpressure();
    logic [W-1:0] opA[6];
    logic [W-1:0] opB[6];
    logic         opS[6];
    exp_t         want[6];
    int           idx;
    int           base;
    int           guard;
    logic         acc;
    opA = '{32'h3F800000, 32'h40000000, 32'h3F800000, 32'h40800000, 32'h3F000000, 32'h40400000};
    opB = '{32'h3F800000, 32'h40000000, 32'h40000000, 32'h3F800000, 32'h3F000000, 32'h3F800000};
    opS = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    want[0] = mk(32'h40000000, 4'hA, 1'b0, 1'b0, 1'b0, 1'b0);
    want[1] = mk(32'h40800000, 4'hB, 1'b0, 1'b0, 1'b0, 1'b0);
    want[2] = mk(32'h40400000, 4'hC, 1'b0, 1'b0, 1'b0, 1'b0);
    want[3] = mk(32'h40400000, 4'hD, 1'b0, 1'b0, 1'b0, 1'b0);
    want[4] = mk(32'h3F800000, 4'hE, 1'b0, 1'b0, 1'b0, 1'b0);
    want[5] = mk(32'h40800000, 4'hF, 1'b0, 1'b0, 1'b0, 1'b0);
    base    = outCount;
    ciReady = 1'b0;
    idx     = 0;
    loadOp(opA[0], opB[0], opS[0], want[0].tag);
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      acc = coReady && ciValid;
      if (acc) sbQ.push_back(want[idx]);
      @(posedge clk);
      #1;
      if (acc) begin
        idx++;
        if (idx < 6) loadOp(opA[idx], opB[idx], opS[idx], want[idx].tag);
        else ciValid = 1'b0;
      end
    end
    nAssert++;
    if (idx !== 3 || coReady !== 1'b0) begin
      nFail++;
      $display("FAIL bp_fill: got accepted=%0d coReady=%b, required accepted=3 coReady=0", idx, coReady);
    end
    nAssert++;
    if (coValid !== 1'b1 || doY !== want[0].y || doTag !== want[0].tag) begin
      nFail++;
      $display("FAIL bp_hold: got valid=%b y=%h tag=%0d, required valid=1 y=%h tag=%0d",
               coValid, doY, doTag, want[0].y, want[0].tag);
    end
    $display("backpressure: %0d accepted with ciReady low", idx);
    ciReady = 1'b1;
    guard   = 0;
    while (idx < 6 && guard < 20) begin
      guard++;
      @(negedge clk);
      acc = coReady && ciValid;
      if (acc) sbQ.push_back(want[idx]);
      @(posedge clk);
      #1;
      if (acc) begin
        idx++;
        if (idx < 6) loadOp(opA[idx], opB[idx], opS[idx], want[idx].tag);
        else ciValid = 1'b0;
      end
    end
    ciValid = 1'b0;
    waitDrain(30);
    repeat (3) @(negedge clk);
    nAssert++;
    if (outCount - base !== 6) begin
      nFail++;
      $display("FAIL bp_count: got %0d results, required 6", outCount - base);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset_inflight();
    int base;
    base    = outCount;
    ciReady = 1'b1;
    sendOp(32'h3F800000, 32'h3F800000, 1'b0, mk(32'h40000000, 4'd1, 1'b0, 1'b0, 1'b0, 1'b0));
    sendOp(32'h40000000, 32'h40000000, 1'b0, mk(32'h40800000, 4'd2, 1'b0, 1'b0, 1'b0, 1'b0));
    ci_rst = 1'b1;
    #1;
    sbQ.delete();
    nAssert++;
    if (coValid !== 1'b0) begin
      nFail++;
      $display("FAIL rst_valid: got coValid=%b during reset, required 0", coValid);
    end
    @(posedge clk);
    #1;
    ci_rst = 1'b0;
    #1;
    nAssert++;
    if (coReady !== 1'b1 || coValid !== 1'b0) begin
      nFail++;
      $display("FAIL rst_release: got ready=%b valid=%b, required ready=1 valid=0", coReady, coValid);
    end
    @(posedge clk);
    #1;
    sendOp(32'h3F800000, 32'h40000000, 1'b0, mk(32'h40400000, 4'd3, 1'b0, 1'b0, 1'b0, 1'b0));
    waitDrain(10);
    repeat (6) @(negedge clk);
    nAssert++;
    if (outCount - base !== 1) begin
      nFail++;
      $display("FAIL rst_results: got %0d results after reset, required 1", outCount - base);
    end
  endtask

  initial begin
    ci_rst  = 1'b1;
    diA     = '0;
    diB     = '0;
    ciADD_n = 1'b0;
    diTag   = '0;
    ciValid = 1'b0;
    ciReady = 1'b1;
    test_reset();
    test_basic();
    test_arith();
    test_backpressure();
    test_reset_inflight();
    $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got simulation still running, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
